avr_pmem_arb: RTL and testbench

- Arbiter/sequencer for the single-port synchronous program memory shared by avr_fetch (instruction fetch), the LPM data-read path and the SPM self-programming path of avr_cpu.
- Grants one access per cycle and returns read data with fixed 1-cycle latency.
- Holds the memory for a programmable write time on SPM.
- Gives fetch a guaranteed slot after every data-side read so the CPU never livelocks.

---
 rtl/avr_pmem_arb.sv | 154 +++++++++++++++
 tb/tb_avr_pmem_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_pmem_arb.sv
// Program-memory arbiter/sequencer for fetch, LPM reads and SPM writes.
// Define AVR_PMEM_ARB_BOOTLOCK_EN to block SPM below BOOT_START (adds spm_err).
module avr_pmem_arb #(
   parameter int AW         = 9,
   parameter int SPM_CYCLES = 4
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
   ,
   parameter logic [AW-1:0] BOOT_START = 9'h1C0
`endif
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          fetch_req,
   input  logic [AW-1:0] fetch_addr,
   output logic          fetch_gnt,
   output logic          fetch_valid,
   output logic [15:0]   fetch_data,
   input  logic          lpm_req,
   input  logic [AW:0]   lpm_addr,
   output logic          lpm_gnt,
   output logic          lpm_valid,
   output logic [7:0]    lpm_data,
   input  logic          spm_req,
   input  logic [AW-1:0] spm_addr,
   input  logic [15:0]   spm_wdata,
   output logic          spm_gnt,
   output logic          spm_done,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata,
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
   output logic          spm_err,
`endif
   output logic          busy
);

   typedef enum logic {IDLE, SPM_HOLD} state_t;

   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_FETCH = 2'd1;
   localparam logic [1:0] SRC_LPM   = 2'd2;

   state_t      state;
   logic [7:0]  cnt;
   logic        fair_flag;
   logic [1:0]  rd_src;
   logic        byte_sel;
   logic [15:0] fetch_q;
   logic [7:0]  lpm_q;
   logic [7:0]  lpm_byte;
   logic        idle;
   logic        spm_lock;
   logic        spm_wr;

   assign idle = (state == IDLE) && !RST;

   // fair_flag gives fetch the slot right after every LPM grant
   assign spm_gnt   = idle && spm_req;
   assign lpm_gnt   = idle && !spm_req && lpm_req &&
                      !(fair_flag && fetch_req);
   assign fetch_gnt = idle && !spm_req && fetch_req &&
                      !(lpm_req && !fair_flag);

`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
   assign spm_lock = spm_addr < BOOT_START;
`else
   assign spm_lock = 1'b0;
`endif

   assign spm_wr    = spm_gnt && !spm_lock;
   assign mem_en    = spm_wr || lpm_gnt || fetch_gnt;
   assign mem_we    = spm_wr;
   assign mem_wdata = spm_wr ? spm_wdata : 16'h0000;

   always_comb begin
      mem_addr = '0;
      unique case (1'b1)
         spm_gnt:   mem_addr = spm_addr;
         lpm_gnt:   mem_addr = lpm_addr[AW:1];
         fetch_gnt: mem_addr = fetch_addr;
         default:   mem_addr = '0;
      endcase
   end

   assign fetch_valid = (rd_src == SRC_FETCH);
   assign lpm_valid   = (rd_src == SRC_LPM);
   assign lpm_byte    = byte_sel ? mem_rdata[15:8] : mem_rdata[7:0];
   assign fetch_data  = fetch_valid ? mem_rdata : fetch_q;
   assign lpm_data    = lpm_valid ? lpm_byte : lpm_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         fair_flag <= 1'b0;
         rd_src    <= SRC_NONE;
         byte_sel  <= 1'b0;
         fetch_q   <= 16'h0000;
         lpm_q     <= 8'h00;
         spm_done  <= 1'b0;
         busy      <= 1'b0;
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
         spm_err   <= 1'b0;
`endif
      end else begin
         rd_src   <= fetch_gnt ? SRC_FETCH :
                     lpm_gnt   ? SRC_LPM   : SRC_NONE;
         if (lpm_gnt)
            byte_sel <= lpm_addr[0];
         if (lpm_gnt)
            fair_flag <= 1'b1;
         else if (fetch_gnt)
            fair_flag <= 1'b0;
         if (fetch_valid)
            fetch_q <= mem_rdata;
         if (lpm_valid)
            lpm_q <= lpm_byte;
         spm_done <= 1'b0;
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
         spm_err  <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (spm_gnt) begin
                  if (spm_lock) begin
                     spm_done <= 1'b1;
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
                     spm_err  <= 1'b1;
`endif
                  end else begin
                     state    <= SPM_HOLD;
                     busy     <= 1'b1;
                     cnt      <= 8'(SPM_CYCLES - 1);
                     spm_done <= (SPM_CYCLES == 1);
                  end
               end
            end
            SPM_HOLD: begin
               if (cnt == 8'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt      <= cnt - 8'd1;
                  spm_done <= (cnt == 8'd1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avr_pmem_arb.sv
// Bench for avr_pmem_arb: directed plan steps then random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_avr_pmem_arb;

   localparam int AW  = 9;
   localparam int SPC = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          fetch_req = 1'b0;
   logic [AW-1:0] fetch_addr = '0;
   logic          fetch_gnt, fetch_valid;
   logic [15:0]   fetch_data;
   logic          lpm_req = 1'b0;
   logic [AW:0]   lpm_addr = '0;
   logic          lpm_gnt, lpm_valid;
   logic [7:0]    lpm_data;
   logic          spm_req = 1'b0;
   logic [AW-1:0] spm_addr = '0;
   logic [15:0]   spm_wdata = '0;
   logic          spm_gnt, spm_done;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic [15:0]   mem_rdata = '0;
   logic          busy;
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
   logic          spm_err;
`endif

   avr_pmem_arb #(.AW(AW), .SPM_CYCLES(SPC)) dut (
      .CLK(CLK), .RST(RST),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid),
      .fetch_data(fetch_data),
      .lpm_req(lpm_req), .lpm_addr(lpm_addr),
      .lpm_gnt(lpm_gnt), .lpm_valid(lpm_valid),
      .lpm_data(lpm_data),
      .spm_req(spm_req), .spm_addr(spm_addr),
      .spm_wdata(spm_wdata), .spm_gnt(spm_gnt),
      .spm_done(spm_done),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
      .spm_err(spm_err),
`endif
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   // memory harness: single-port synchronous RAM
   logic [15:0] ram [512];
   always @(posedge CLK) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   // behavioural model state
   logic [15:0] m_mem [512];
   int          m_hold;
   bit          m_fair;
   int          m_pend;
   logic [15:0] m_pdata;
   logic [15:0] m_lastf;
   logic [7:0]  m_lastl;
   bit          m_lkdone;
   bit          g_f, g_l, g_s;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic setw(input int a, input logic [15:0] d);
      ram[a]   = d;
      m_mem[a] = d;
   endtask

   function automatic bit locked(input logic [AW-1:0] a);
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
      return a < 9'h1C0;
`else
      return a != a;
`endif
   endfunction

   function automatic logic [7:0] pick(input logic [AW:0] a);
      logic [15:0] w;
      w = m_mem[a[AW:1]];
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   // one clock: check at negedge, advance model, return #1 after posedge
   task automatic cycle();
      bit ef, el, es, ew;
      logic [AW-1:0] ea;
      @(negedge CLK);
      ef = 0; el = 0; es = 0;
      if (!RST && m_hold == 0) begin
         if (spm_req) es = 1;
         else if (lpm_req && !(m_fair && fetch_req)) el = 1;
         else if (fetch_req) ef = 1;
      end
      ew = es && !locked(spm_addr);
      ea = es ? spm_addr : el ? lpm_addr[AW:1] : fetch_addr;
      chk("spm_gnt", spm_gnt, es);
      chk("lpm_gnt", lpm_gnt, el);
      chk("fetch_gnt", fetch_gnt, ef);
      chk("mem_en", mem_en, ew || el || ef);
      chk("mem_we", mem_we, ew);
      if (ew || el || ef) chk("mem_addr", mem_addr, ea);
      if (ew) chk("mem_wdata", mem_wdata, spm_wdata);
      chk("busy", busy, m_hold > 0);
      chk("spm_done", spm_done, m_hold == 1 || m_lkdone);
`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
      chk("spm_err", spm_err, m_lkdone);
`endif
      chk("fetch_valid", fetch_valid, m_pend == 1);
      chk("lpm_valid", lpm_valid, m_pend == 2);
      chk("fetch_data", fetch_data,
          m_pend == 1 ? m_pdata : m_lastf);
      chk("lpm_data", lpm_data,
          m_pend == 2 ? m_pdata[7:0] : m_lastl);
      g_f = ef; g_l = el; g_s = es;
      if (RST) begin
         m_hold = 0; m_fair = 0; m_pend = 0; m_pdata = '0;
         m_lastf = '0; m_lastl = '0; m_lkdone = 0;
      end else begin
         if (m_pend == 1) m_lastf = m_pdata;
         if (m_pend == 2) m_lastl = m_pdata[7:0];
         m_pend = 0;
         if (ef) begin
            m_pend = 1; m_pdata = m_mem[fetch_addr];
         end
         if (el) begin
            m_pend = 2; m_pdata = {8'h00, pick(lpm_addr)};
         end
         if (m_hold > 0) m_hold--;
         m_lkdone = 0;
         if (es) begin
            if (locked(spm_addr)) m_lkdone = 1;
            else begin
               m_mem[spm_addr] = spm_wdata;
               m_hold = SPC;
            end
         end
         if (el) m_fair = 1;
         else if (ef) m_fair = 0;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) setw(i, 16'($urandom));
      m_hold = 0; m_fair = 0; m_pend = 0; m_pdata = '0;
      m_lastf = '0; m_lastl = '0; m_lkdone = 0;
      repeat (2) @(posedge CLK);
      #1;
      cycle();
      RST = 1'b0;
      cycle();

      // fetch streaming
      setw(0, 16'hE0A4); setw(1, 16'h50A1); setw(2, 16'h0000);
      fetch_req = 1; fetch_addr = 9'd0;
      cycle();
      chk("tp1_d0", fetch_data, 16'hE0A4);
      fetch_addr = 9'd1;
      cycle();
      chk("tp1_d1", fetch_data, 16'h50A1);
      fetch_addr = 9'd2;
      cycle();
      chk("tp1_v2", fetch_valid, 1'b1);
      fetch_req = 0;
      cycle();

      // fetch vs lpm fairness
      setw(8, 16'hBEEF);
      fetch_req = 1; fetch_addr = 9'd3;
      lpm_req = 1; lpm_addr = 10'h011;
      cycle();
      chk("tp2_lpm", lpm_data, 8'hBE);
      cycle();
      cycle();
      fetch_req = 0; lpm_req = 0;
      cycle();

      // SPM write with fetch pending
      fetch_req = 1; fetch_addr = 9'd5;
      spm_req = 1; spm_addr = 9'h010; spm_wdata = 16'h1234;
      cycle();
      spm_req = 0;
      repeat (SPC + 1) cycle();
      fetch_addr = 9'h010;
      cycle();
`ifndef AVR_PMEM_ARB_BOOTLOCK_EN
      chk("tp3_rd", fetch_data, 16'h1234);
`endif
      fetch_req = 0;
      cycle();

      // reset during hold
      fetch_req = 1; fetch_addr = 9'd7;
      spm_req = 1; spm_addr = 9'h1C4; spm_wdata = 16'hA5C3;
      cycle();
      spm_req = 0;
      cycle();
      cycle();
      RST = 1;
      cycle();
      chk("tp4_busy", busy, 1'b0);
      chk("tp4_done", spm_done, 1'b0);
      RST = 0;
      cycle();
      cycle();
      fetch_req = 0;
      cycle();

`ifdef AVR_PMEM_ARB_BOOTLOCK_EN
      spm_req = 1; spm_addr = 9'h020; spm_wdata = 16'hFFFF;
      cycle();
      spm_req = 0;
      cycle();
      spm_req = 1; spm_addr = 9'h1C4; spm_wdata = 16'h5A5A;
      cycle();
      spm_req = 0;
      repeat (SPC + 1) cycle();
`endif

      // random traffic; granted requesters drop/renew
      for (int n = 0; n < 600; n++) begin
         if (!fetch_req || g_f) begin
            fetch_req  = $urandom_range(0, 3) != 0;
            fetch_addr = 9'($urandom);
         end
         if (!lpm_req || g_l) begin
            lpm_req  = $urandom_range(0, 2) == 0;
            lpm_addr = 10'($urandom);
         end
         if (!spm_req || g_s) begin
            spm_req   = $urandom_range(0, 15) == 0;
            spm_addr  = 9'($urandom);
            spm_wdata = 16'($urandom);
         end
         RST = $urandom_range(0, 199) == 0;
         cycle();
      end
      RST = 0; fetch_req = 0; lpm_req = 0; spm_req = 0;
      repeat (SPC + 2) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
